// File: rtl/imem_boot_loader.sv
// Streams a program image into instruction memory while holding the core in stall.
// Define IMEM_LOAD_CHECKSUM_EN to require a trailing 32-bit sum word before release.
module imem_boot_loader #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    load_count,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [2:0]    dbg_state_o
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
    localparam logic [2:0] CHECK = 3'd2;
`endif
    localparam logic [2:0] DONE = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    // Handshake: a word moves when in_valid and in_ready are both high in the
    // same cycle; in_valid while in_ready is low is simply ignored.
    logic [2:0] state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic [7:0] count_q, count_d;
    logic       xfer;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

`ifdef IMEM_LOAD_CHECKSUM_EN
    assign in_ready = (state_q == LOAD) || (state_q == CHECK);
`else
    assign in_ready = (state_q == LOAD);
`endif
    assign xfer        = in_valid & in_ready;
    assign mem_we      = (state_q == LOAD) & xfer;
    assign mem_waddr   = wcnt_q[AW-1:0];
    assign mem_wdata   = in_data;
    assign cpu_hold    = (state_q != DONE);
    assign done        = (state_q == DONE);
    assign error       = (state_q == ERR);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        count_d = count_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    if (load_count == 8'd0 || {1'b0, load_count} > DEPTH_W) begin
                        state_d = ERR;
                    end else begin
                        state_d = LOAD;
                        count_d = load_count;
                        wcnt_d  = 8'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                        sum_d   = 32'd0;
`endif
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    wcnt_d = wcnt_q + 8'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    sum_d  = sum_q + in_data;
                    if (wcnt_q + 8'd1 == count_q) state_d = CHECK;
`else
                    if (wcnt_q + 8'd1 == count_q) state_d = DONE;
`endif
                end
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            CHECK: begin
                // The trailer is consumed here but never reaches the memory port.
                if (xfer) state_d = (in_data == sum_q) ? DONE : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= 8'd0;
            count_q <= 8'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            count_q <= count_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

endmodule
